// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared types and constants for the FIFO write-port arbiter.
// Optional statistics are enabled with the FIFO_WR_ARB_STATS_EN macro.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int BEAT_CNT_W = 4;
  localparam int STAT_W     = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches req starting just
// above 'last' and wrapping modulo N_REQ; returns the first hit.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] idx
);

  int               cand_i;
  logic [IDX_W-1:0] cand;

  // Scan candidates last+1 .. last+N_REQ (mod N_REQ); the first request wins.
  always_comb begin
    valid  = 1'b0;
    sel    = {N_REQ{1'b0}};
    idx    = {IDX_W{1'b0}};
    cand_i = 0;
    cand   = {IDX_W{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      cand_i = (int'(last) + k) % N_REQ;
      cand   = IDX_W'(cand_i);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        sel[cand] = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port among N_REQ
// producers, with bounded bursts and gating on the FIFO full flag.
// Define FIFO_WR_ARB_STATS_EN to add the grant_cnt / stall_cnt outputs.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic                   fifo_full,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   fifo_w_en,
  output logic [WIDTH-1:0]       fifo_data_in,
  output logic                   busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]       stall_cnt
`endif
);

  localparam int                    IDX_W      = $clog2(N_REQ);
  localparam logic [IDX_W-1:0]      LAST_RST   = IDX_W'(N_REQ - 1);
  localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(MAX_BURST);
  localparam logic [BEAT_CNT_W-1:0] BEAT_ONE   = BEAT_CNT_W'(1);

  state_e                  state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic                    pick_valid;
  logic [N_REQ-1:0]        pick_sel;
  logic [IDX_W-1:0]        pick_idx;
  logic                    req_g;
  logic [BEAT_CNT_W-1:0]   beat_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .sel   (pick_sel),
    .idx   (pick_idx)
  );

  // State register: arbiter state, grant, round-robin pointer and beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= {N_REQ{1'b0}};
      last_q     <= LAST_RST;
      beat_cnt_q <= {BEAT_CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state: pick a requester in IDLE; count beats and release in GRANT.
  always_comb begin
    req_g      = |(req & gnt_q);
    beat_nxt   = beat_cnt_q + BEAT_ONE;
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          gnt_d      = pick_sel;
          last_d     = pick_idx;
          beat_cnt_d = {BEAT_CNT_W{1'b0}};
        end else begin
          gnt_d = {N_REQ{1'b0}};
        end
      end
      GRANT: begin
        if (!req_g) begin
          // Granted producer has nothing more to send.
          state_d = IDLE;
          gnt_d   = {N_REQ{1'b0}};
        end else if (!fifo_full) begin
          beat_cnt_d = beat_nxt;
          if (beat_nxt == BURST_LAST) begin
            state_d = IDLE;
            gnt_d   = {N_REQ{1'b0}};
          end else begin
            state_d = GRANT;
          end
        end else begin
          // Stalled on full: hold the grant and the count.
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N_REQ{1'b0}};
      end
    endcase
  end

  // Outputs: same-cycle accept, FIFO write strobe and data mux; muted in reset.
  always_comb begin
    gnt          = gnt_q;
    busy         = (state_q == GRANT);
    fifo_data_in = {WIDTH{1'b0}};
    if (rst) begin
      ack = {N_REQ{1'b0}};
    end else begin
      ack = gnt_q & req & {N_REQ{~fifo_full}};
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_q[i]) begin
          fifo_data_in = fifo_data_in | req_data[i*WIDTH +: WIDTH];
        end else begin
          fifo_data_in = fifo_data_in;
        end
      end
    end
    fifo_w_en = |ack;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ*STAT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [STAT_W-1:0]       stall_cnt_q, stall_cnt_d;

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= {(N_REQ*STAT_W){1'b0}};
      stall_cnt_q <= {STAT_W{1'b0}};
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Statistics update: count grants issued from IDLE and full-flag stalls.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if ((state_q == IDLE) && pick_valid && pick_sel[i]) begin
        grant_cnt_d[i*STAT_W +: STAT_W] = sat_inc(grant_cnt_q[i*STAT_W +: STAT_W]);
      end else begin
        grant_cnt_d[i*STAT_W +: STAT_W] = grant_cnt_q[i*STAT_W +: STAT_W];
      end
    end
    if ((state_q == GRANT) && req_g && fifo_full) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus randomized traffic for fifo_wr_arb,
// checked cycle by cycle against a behavioural arbitration model.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  gnt, ack;
  logic          fifo_w_en, busy;
  logic [W-1:0]  fifo_data_in;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arb #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .gnt          (gnt),
    .ack          (ack),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  wire [17:0] obs = {gnt, ack, fifo_w_en, fifo_data_in, busy};

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the port, beats taken, last winner, stats.
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = N - 1;
  int m_grants[N];
  int m_stall = 0;
  int seq[N];

  // Expected {gnt, ack, w_en, data, busy} for the current inputs.
  function automatic logic [17:0] exp_outputs();
    logic [3:0] g, a;
    logic [7:0] d;
    g = 4'd0; a = 4'd0; d = 8'd0;
    if (m_owner >= 0) begin
      g = 4'd1 << m_owner;
      if (!rst) begin
        d = req_data[m_owner*W +: W];
        if (req[m_owner] && !fifo_full) a = 4'd1 << m_owner;
      end
    end
    return {g, a, |a, d, (m_owner >= 0)};
  endfunction

  function automatic void refresh_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(i * 32 + (seq[i] % 32));
  endfunction

  task automatic drive(input logic [3:0] r, input logic f, input logic rs);
    @(negedge clk);
    req = r; fifo_full = f; rst = rs;
    refresh_data();
    #1;
  endtask

  // Advance one clock and move the model along the arbitration rules.
  task automatic tick();
    logic [17:0] e;
    bit found;
    int c;
    e = exp_outputs();
    @(posedge clk);
    #1;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_last = N - 1; m_stall = 0;
      for (int i = 0; i < N; i++) m_grants[i] = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req[c]) begin
          found = 1; m_owner = c; m_last = c; m_beats = 0;
          if (m_grants[c] < 65535) m_grants[c]++;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (fifo_full) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      m_beats++;
      if (m_beats == MB) m_owner = -1;
    end
    for (int i = 0; i < N; i++) if (e[10+i]) seq[i]++;
  endtask

  task automatic do_reset();
    drive(4'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(4'hF, 1'b0, 1'b1);
    tick();
    drive(4'hF, 1'b0, 1'b1);
    n_checks++;
    if (obs !== 18'd0) begin
      n_fail++; $display("FAIL reset_in_rst: got %h expected %h", obs, 18'd0);
    end
    n_checks++;
    if (obs !== exp_outputs()) begin
      n_fail++; $display("FAIL reset_model: got %h expected %h", obs, exp_outputs());
    end
    tick();
    drive(4'd0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 18'd0) begin
      n_fail++; $display("FAIL reset_after: got %h expected %h", obs, 18'd0);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(4'b0100, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_outputs()) begin
        n_fail++; $display("FAIL single_model cyc %0d: got %h expected %h", k, obs, exp_outputs());
      end
      n_checks++;
      if (fifo_w_en !== ((k % 5) != 0)) begin
        n_fail++; $display("FAIL single_wen cyc %0d: got %b expected %b", k, fifo_w_en, (k % 5) != 0);
      end
      if (k == 1) begin
        n_checks++;
        if (gnt !== 4'b0100) begin
          n_fail++; $display("FAIL single_gnt: got %b expected 0100", gnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [3:0] prev;
    int burst;
    bit done;
    do_reset();
    prev = 4'd0; burst = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      drive(4'hF, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_outputs()) begin
        n_fail++; $display("FAIL rr_model cyc %0d: got %h expected %h", k, obs, exp_outputs());
      end
      if (gnt != 4'd0 && prev == 4'd0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
      end
      if (gnt == 4'd0 && prev != 4'd0) begin
        n_checks++;
        if (burst != MB) begin
          n_fail++; $display("FAIL rr_burst_len: got %0d expected %0d", burst, MB);
        end
        burst = 0;
      end
      if (fifo_w_en) burst++;
      prev = gnt;
      if (order.size() == 8) begin
        done = 1;
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
          n_checks++;
          if (grant_cnt[i*16 +: 16] !== 16'd2) begin
            n_fail++; $display("FAIL stats_grant_cnt[%0d]: got %0d expected 2", i, grant_cnt[i*16 +: 16]);
          end
        end
        n_checks++;
        if (stall_cnt !== 16'd0) begin
          n_fail++; $display("FAIL stats_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
      end
      tick();
    end
    n_checks++;
    if (order.size() != 8) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d expected 8", order.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (order[i] != exp_order[i]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] eg;
    logic ew;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(4'b0010, (k >= 2 && k <= 4), 1'b0);
      eg = (k >= 1 && k <= 7) ? 4'b0010 : 4'b0000;
      ew = (k == 1) || (k >= 5 && k <= 7);
      n_checks++;
      if (obs !== exp_outputs()) begin
        n_fail++; $display("FAIL stall_model cyc %0d: got %h expected %h", k, obs, exp_outputs());
      end
      n_checks++;
      if (gnt !== eg || fifo_w_en !== ew || ack !== (ew ? 4'b0010 : 4'b0000)) begin
        n_fail++; $display("FAIL stall_seq cyc %0d: got gnt=%b wen=%b ack=%b expected gnt=%b wen=%b", k, gnt, fifo_w_en, ack, eg, ew);
      end
      tick();
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_checks++;
    if (stall_cnt !== 16'd3) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_early_release();
    logic [3:0] eg;
    logic ew;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive((k < 3) ? 4'b0110 : 4'b0100, 1'b0, 1'b0);
      eg = (k >= 1 && k <= 3) ? 4'b0010 : ((k >= 5) ? 4'b0100 : 4'b0000);
      ew = (k == 1) || (k == 2) || (k >= 5);
      n_checks++;
      if (obs !== exp_outputs()) begin
        n_fail++; $display("FAIL early_model cyc %0d: got %h expected %h", k, obs, exp_outputs());
      end
      n_checks++;
      if (gnt !== eg || fifo_w_en !== ew) begin
        n_fail++; $display("FAIL early_seq cyc %0d: got gnt=%b wen=%b expected gnt=%b wen=%b", k, gnt, fifo_w_en, eg, ew);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'hF, 1'b0, (k == 3));
      n_checks++;
      if (obs !== exp_outputs()) begin
        n_fail++; $display("FAIL midrst_model cyc %0d: got %h expected %h", k, obs, exp_outputs());
      end
      if (k == 3) begin
        n_checks++;
        if (fifo_w_en !== 1'b0 || ack !== 4'd0 || fifo_data_in !== 8'd0) begin
          n_fail++; $display("FAIL midrst_wen: got wen=%b ack=%b data=%h expected 0", fifo_w_en, ack, fifo_data_in);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (gnt !== 4'd0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL midrst_gnt: got gnt=%b busy=%b expected 0", gnt, busy);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (gnt !== 4'b0001) begin
          n_fail++; $display("FAIL midrst_next: got gnt=%b expected 0001", gnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'd0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) r[i] = ($urandom_range(9) != 0);
        else      r[i] = ($urandom_range(2) == 0);
      end
      drive(r, ($urandom_range(3) == 0), ($urandom_range(99) == 0));
      n_checks++;
      if (obs !== exp_outputs()) begin
        n_fail++; $display("FAIL rand_model cyc %0d: got %h expected %h", k, obs, exp_outputs());
      end
      tick();
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (grant_cnt[i*16 +: 16] !== 16'(m_grants[i])) begin
        n_fail++; $display("FAIL rand_grant_cnt[%0d]: got %0d expected %0d", i, grant_cnt[i*16 +: 16], m_grants[i]);
      end
    end
    n_checks++;
    if (stall_cnt !== 16'(m_stall)) begin
      n_fail++; $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, m_stall);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_grants[i] = 0;
      seq[i] = i * 3;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter sharing the single write port of the team's synchronous FIFO among N_REQ producers. Each producer raises a request and presents data; the arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_en`/`data_in`. It gates writes on the FIFO `full` flag so no write is ever issued into a full FIFO. It sits directly in front of the FIFO write side.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `WIDTH`, 8: data width; matches the FIFO `width`
- `MAX_BURST`, 4: max accepted beats per grant, 1..15

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req` in N_REQ: per-requester request; held high while data is pending
- `req_data` in N_REQ*WIDTH: requester i data in bits [i*WIDTH +: WIDTH]
- `fifo_full` in 1: FIFO `full` flag
- `gnt` out N_REQ: registered one-hot grant, all-zero when idle
- `ack` out N_REQ: beat accepted this cycle; combinational, `gnt & req & {N{~fifo_full}}`
- `fifo_w_en` out 1: FIFO write enable, equal to `|ack`
- `fifo_data_in` out WIDTH: `req_data` slice of the granted requester; 0 when idle
- `busy` out 1: state is GRANT

## Operation
- States: IDLE, GRANT.
- IDLE: if `|req`, select the first requester with `req` high, searching from `last+1` upward modulo N_REQ. Register its one-hot into `gnt` and store its index in `last`. Clear `beat_cnt` and go to GRANT. Otherwise stay in IDLE with `gnt`=0.
- GRANT, granted index g:
  - A beat is accepted when `req[g] && !fifo_full`: `ack[g]`=1, `fifo_w_en`=1, `beat_cnt`++.
  - Stall when `req[g] && fifo_full`: no write, `beat_cnt` unchanged, grant held indefinitely.
  - Release when `req[g]`=0, or when an accepted beat brings `beat_cnt` to MAX_BURST. `gnt` goes to 0 next cycle and state returns to IDLE.
- Requesters other than g are ignored during GRANT, even if they drop or raise `req`.
- `last` resets to N_REQ-1, so requester 0 has first priority after reset.
- `beat_cnt` is 4 bits wide and never exceeds MAX_BURST.
- Reset values: `gnt`=0, `ack`=0, `fifo_w_en`=0, `fifo_data_in`=0, `busy`=0, state IDLE, `beat_cnt`=0, `last`=N_REQ-1, all stats counters 0.
- Reset asserted mid-burst: state, grant and counters clear on that edge. The in-flight write for that cycle is suppressed, with `fifo_w_en` forced to 0 while `rst`=1.

## Timing
- Arbitration latency: `req` sampled high in IDLE gives `gnt` high the next cycle. The first write can occur in that same grant cycle.
- Release costs exactly one idle cycle before the next grant.
  - Steady contention: MAX_BURST writes, then 1 bubble, repeated.
- `ack` and `fifo_w_en` are same-cycle combinational from `req`, `gnt` and `fifo_full`.
  - A requester advances its data on the clock edge where `ack` is sampled high.
- `fifo_full` is consumed in the cycle it is presented; there is no registered lookahead.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined:
  - Adds output `grant_cnt` [N_REQ*16]: per-requester 16-bit saturating counts of grants issued.
  - Adds output `stall_cnt` [16]: saturating count of stall cycles.
  - All counters clear on `rst`.
- Not defined: those ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package `fifo_wr_arb_pkg` holds:
  - the state enum (IDLE, GRANT);
  - the `BEAT_CNT_W`=4 constant;
  - the `STAT_W`=16 constant.
- One sub-module, `rr_pick`: combinational round-robin selector.
  - Inputs: `req`, `last`.
  - Outputs: `valid`, one-hot `sel`, index `idx`.

## Test plan
- Single requester, N_REQ=4, MAX_BURST=4:
  - Stimulus: reset, then `req[2]` held high, FIFO never full.
  - Response: `gnt`=4'b0100 one cycle after `req`; writes of 4,4,… beats separated by single idle cycles.
- All four requesting continuously from reset.
  - Response: grant order 0,1,2,3,0; each burst is exactly 4 `fifo_w_en` pulses carrying that requester's data.
- Full stall during a grant:
  - Stimulus: `fifo_full`=1 for 3 cycles mid-grant.
  - Response: `ack`=0 and `fifo_w_en`=0 for those cycles; `gnt` held; `beat_cnt` resumes; the burst still totals 4 beats.
- Early release:
  - Stimulus: requester 1 drops `req` after 2 beats.
  - Response: `gnt` clears next cycle; the next grant goes to requester 2 (if requesting) after 1 idle cycle.
- Reset mid-burst:
  - Stimulus: `rst` pulsed after 2 beats.
  - Response: `fifo_w_en`=0 during reset; `gnt`=0; the next grant goes to requester 0.
- With `FIFO_WR_ARB_STATS_EN`:
  - Stimulus: after the round-robin test, 2 full rotations.
  - Response: `grant_cnt` reads 2 per requester; `stall_cnt` reads 0.
